// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: memop encodings, MMIO
// register offsets, STATUS bit indices and access-size helpers.
package dmem_pkg;

  // Memop encodings as issued by the core (bit 2 = unsigned load variant)
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  // Access size carried in op[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // MMIO byte offsets relative to the window base
  localparam logic [4:0] MMIO_LED      = 5'h00;
  localparam logic [4:0] MMIO_CYC_LO   = 5'h04;
  localparam logic [4:0] MMIO_CYC_HI   = 5'h08;
  localparam logic [4:0] MMIO_STATUS   = 5'h0C;
  localparam logic [4:0] MMIO_ERR_ADDR = 5'h10;

  // STATUS register bit positions
  localparam int unsigned ST_MISALIGN = 0;
  localparam int unsigned ST_UNMAPPED = 1;

  // Source of the registered read data
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_MMIO = 2'd2
  } rd_sel_e;

  // Only the five defined encodings are legal accesses
  function automatic logic op_valid(input logic [2:0] op);
    logic ok;
    ok = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
         (op == OP_LBU) || (op == OP_LHU);
    return ok;
  endfunction

  // Natural alignment check for the access size
  function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] lo);
    logic ok;
    case (op[1:0])
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lo[0];
      SZ_WORD: ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-lane write enables for a store of the given size at lane lo
  function automatic logic [3:0] byte_enable(input logic [2:0] op, input logic [1:0] lo);
    logic [3:0] be;
    case (op[1:0])
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Word-organised data RAM with per-byte write enables.
// Read is registered and read-first (rdata shows the word before a same-cycle
// write). Contents are never reset.
//   clk   : clock
//   we    : write strobe
//   be    : byte-lane enables
//   addr  : word address
//   wdata : lane-replicated write data
//   rdata : registered read word
module dmem_bytelane_ram #(
  parameter int unsigned AW = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  // Read-first port: old word captured, selected lanes overwritten
  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's dmem port: RAM with RV32 sub-word
// lane steering and load extension, plus an MMIO window with LED register,
// 64-bit cycle counter, sticky error STATUS and ERR_ADDR.
//   clk         : clock, all state updates on posedge
//   clr         : asynchronous active-high reset
//   dmemaddr    : byte address
//   dmemdatain  : right-aligned store data
//   dmemop      : access type (byte/half/word, signed/unsigned)
//   dmemwe      : 1 = store, 0 = load/idle
//   dmemdataout : formatted load data, one posedge after the access
//   leds        : LED register
//   err         : OR of sticky STATUS bits
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_AW    = 15,
  parameter logic [31:0] RAM_BASE  = 32'h0010_0000,
  parameter logic [31:0] MMIO_BASE = 32'h0020_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemdatain,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  output logic [31:0] dmemdataout,
  output logic [31:0] leds,
  output logic        err
);

  localparam int unsigned TAG_LSB = RAM_AW + 2;

  // Access decode
  logic        in_ram;
  logic        in_mmio;
  logic        misalign;
  logic        unmapped;
  logic        acc_ok;
  logic [4:0]  mmio_ofs;

  // RAM port
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // Registered state
  rd_sel_e     rd_sel;
  logic [1:0]  rd_lo;
  logic [2:0]  rd_op;
  logic [31:0] mmio_q;
  logic [1:0]  status;
  logic [31:0] err_addr;
  logic [31:0] shadow;
  logic [63:0] cycle_cnt;

  // Next-state values
  rd_sel_e     rd_sel_nxt;
  logic [31:0] mmio_rdata;
  logic [31:0] leds_nxt;
  logic [1:0]  status_nxt;
  logic [31:0] err_addr_nxt;
  logic [31:0] shadow_nxt;

  // Load formatting
  logic [31:0] rd_src;
  logic [31:0] rd_shift;

  // Region and alignment; an MMIO access must be a word, undefined ops are misaligned
  always_comb begin
    in_ram   = (dmemaddr[31:TAG_LSB] == RAM_BASE[31:TAG_LSB]);
    in_mmio  = (dmemaddr[31:5] == MMIO_BASE[31:5]);
    mmio_ofs = dmemaddr[4:0];
    misalign = !op_valid(dmemop) || !op_aligned(dmemop, dmemaddr[1:0]) ||
               (in_mmio && (dmemop[1:0] != SZ_WORD));
    unmapped = !in_ram && !in_mmio;
    acc_ok   = !misalign && !unmapped;
  end

  // Store lanes: replicate the right-aligned data, byte enables pick the lanes
  always_comb begin
    ram_we = dmemwe && acc_ok && in_ram;
    ram_be = byte_enable(dmemop, dmemaddr[1:0]);
    case (dmemop[1:0])
      SZ_BYTE: ram_wdata = {4{dmemdatain[7:0]}};
      SZ_HALF: ram_wdata = {2{dmemdatain[15:0]}};
      default: ram_wdata = dmemdatain;
    endcase
  end

  dmem_bytelane_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (ram_be),
    .addr (dmemaddr[TAG_LSB-1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // MMIO read mux, register updates and error capture
  always_comb begin
    rd_sel_nxt   = SEL_NONE;
    mmio_rdata   = '0;
    leds_nxt     = leds;
    status_nxt   = status;
    err_addr_nxt = err_addr;
    shadow_nxt   = shadow;

    // Offsets 0x14-0x1C fall to the default and read as zero
    case (mmio_ofs)
      MMIO_LED:      mmio_rdata = leds;
      MMIO_CYC_LO:   mmio_rdata = cycle_cnt[31:0];
      MMIO_CYC_HI:   mmio_rdata = shadow;
      MMIO_STATUS:   mmio_rdata = {30'h0, status};
      MMIO_ERR_ADDR: mmio_rdata = err_addr;
      default:       mmio_rdata = '0;
    endcase

    if (!acc_ok) begin
      err_addr_nxt = dmemaddr;
      if (misalign) status_nxt[ST_MISALIGN] = 1'b1;
      else          status_nxt[ST_UNMAPPED] = 1'b1;
    end else if (in_ram) begin
      rd_sel_nxt = SEL_RAM;
    end else begin
      rd_sel_nxt = SEL_MMIO;
      if (dmemwe) begin
        // Read-only registers silently ignore writes
        case (mmio_ofs)
          MMIO_LED:    leds_nxt   = dmemdatain;
          MMIO_STATUS: status_nxt = '0;
          default:     ;
        endcase
      end else if (mmio_ofs == MMIO_CYC_LO) begin
        // Snapshot the high word paired with the low word being returned
        shadow_nxt = cycle_cnt[63:32];
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_sel    <= SEL_NONE;
      rd_lo     <= '0;
      rd_op     <= '0;
      mmio_q    <= '0;
      leds      <= '0;
      status    <= '0;
      err_addr  <= '0;
      shadow    <= '0;
      cycle_cnt <= '0;
      err       <= 1'b0;
    end else begin
      rd_sel    <= rd_sel_nxt;
      rd_lo     <= dmemaddr[1:0];
      rd_op     <= dmemop;
      mmio_q    <= mmio_rdata;
      leds      <= leds_nxt;
      status    <= status_nxt;
      err_addr  <= err_addr_nxt;
      shadow    <= shadow_nxt;
      cycle_cnt <= cycle_cnt + 64'd1;
      err       <= |status_nxt;
    end
  end

  // Load formatting from the registered word and captured access fields
  always_comb begin
    case (rd_sel)
      SEL_RAM:  rd_src = ram_rdata;
      SEL_MMIO: rd_src = mmio_q;
      default:  rd_src = '0;
    endcase
    rd_shift = rd_src >> {rd_lo, 3'b000};
    case (rd_op[1:0])
      SZ_BYTE: dmemdataout = rd_op[2] ? {24'h0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: dmemdataout = rd_op[2] ? {16'h0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: dmemdataout = rd_src;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, multi-cycle
// corner sequences (counter wrap, async reset) and a randomized phase checked
// against a byte-addressed reference model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam logic [31:0] RAM_BASE  = 32'h0010_0000;
  localparam logic [31:0] RAM_BYTES = 32'h0002_0000;
  localparam logic [31:0] MMIO_BASE = 32'h0020_0000;
  localparam logic [31:0] A_LED     = MMIO_BASE + 32'h00;
  localparam logic [31:0] A_CLO     = MMIO_BASE + 32'h04;
  localparam logic [31:0] A_CHI     = MMIO_BASE + 32'h08;
  localparam logic [31:0] A_ST      = MMIO_BASE + 32'h0C;
  localparam logic [31:0] A_EA      = MMIO_BASE + 32'h10;

  logic        clk;
  logic        clr;
  logic [31:0] dmemaddr;
  logic [31:0] dmemdatain;
  logic [2:0]  dmemop;
  logic        dmemwe;
  logic [31:0] dmemdataout;
  logic [31:0] leds;
  logic        err;

  int total = 0;
  int bad   = 0;

  dmem_responder dut (
    .clk        (clk),
    .clr        (clr),
    .dmemaddr   (dmemaddr),
    .dmemdatain (dmemdatain),
    .dmemop     (dmemop),
    .dmemwe     (dmemwe),
    .dmemdataout(dmemdataout),
    .leds       (leds),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    bit          cd;
    logic [31:0] dout;
    logic [31:0] leds;
    logic        err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic we, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] d, input bit cd, input logic [31:0] dout,
                              input logic [31:0] l, input logic e);
    vec_t v;
    v.we = we; v.op = op; v.addr = a; v.data = d;
    v.cd = cd; v.dout = dout; v.leds = l; v.err = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One access: drive at negedge, outputs settle by the following negedge
  task automatic step(input logic we, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] d);
    dmemwe = we; dmemop = op; dmemaddr = a; dmemdatain = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: byte memory plus architectural MMIO state
  logic [7:0]  mem_m [logic [31:0]];
  logic [1:0]  st_m;
  logic [31:0] leds_m;
  logic [31:0] ea_m;

  task automatic model(input logic we, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] exp, output bit known);
    int unsigned sz;
    bit is_ram, is_mmio, mis;
    logic [31:0] v;
    logic [31:0] off;
    sz      = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    is_ram  = (a >= RAM_BASE) && (a < RAM_BASE + RAM_BYTES);
    is_mmio = (a >= MMIO_BASE) && (a < MMIO_BASE + 32'd32);
    mis     = ((a % sz) != 0) || (is_mmio && sz != 4);
    exp     = '0;
    known   = 1'b1;
    if (mis) begin
      st_m[0] = 1'b1; ea_m = a;
    end else if (!is_ram && !is_mmio) begin
      st_m[1] = 1'b1; ea_m = a;
    end else if (is_ram) begin
      v = '0;
      for (int i = 0; i < int'(sz); i++) begin
        if (mem_m.exists(a + 32'(i))) v = v | (32'(mem_m[a + 32'(i)]) << (8*i));
        else known = 1'b0;
      end
      if (!op[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      exp = v;
      if (we) for (int i = 0; i < int'(sz); i++) mem_m[a + 32'(i)] = d[8*i +: 8];
    end else begin
      off = a - MMIO_BASE;
      case (off)
        32'h00:  exp = leds_m;
        32'h0C:  exp = {30'h0, st_m};
        32'h10:  exp = ea_m;
        default: exp = '0;
      endcase
      if (we) begin
        if (off == 32'h00) leds_m = d;
        if (off == 32'h0C) st_m = '0;
      end
    end
  endtask

  // Random address over RAM window, top-of-RAM edge, MMIO (no counter regs), unmapped
  function automatic logic [31:0] rand_addr();
    logic [31:0] mofs [6];
    int unsigned r;
    mofs = '{32'h00, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
    r = $urandom_range(0, 9);
    if (r < 5)       return RAM_BASE + 32'h100 + 32'($urandom_range(0, 63));
    else if (r == 5) return RAM_BASE + RAM_BYTES - 32'd4 + 32'($urandom_range(0, 7));
    else if (r < 8)  return MMIO_BASE + mofs[$urandom_range(0, 5)] + 32'($urandom_range(0, 3));
    else if (r == 8) return 32'h4000_0000 | 32'($urandom_range(0, 32'hFFFF));
    else             return MMIO_BASE + 32'd32 + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [2:0]  ops [5];
    logic [31:0] e, a, d;
    logic [2:0]  op;
    logic        we;
    bit          k;

    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

    clr = 1'b1; dmemwe = 1'b0; dmemop = OP_LW; dmemaddr = RAM_BASE; dmemdatain = '0;
    #12;
    chk("reset dout", dmemdataout, 32'h0);
    chk("reset leds", leds, 32'h0);
    chk("reset err", err, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    //         we   op      addr                data           cd dout           leds  err
    vt.push_back(mk(1, OP_LW,  RAM_BASE,           32'hDEADBEEF, 0, 32'h0,        0, 0));
    vt.push_back(mk(0, OP_LB,  RAM_BASE,           0,            1, 32'hFFFFFFEF, 0, 0));
    vt.push_back(mk(0, OP_LBU, RAM_BASE + 3,       0,            1, 32'h000000DE, 0, 0));
    vt.push_back(mk(0, OP_LH,  RAM_BASE + 2,       0,            1, 32'hFFFFDEAD, 0, 0));
    vt.push_back(mk(0, OP_LHU, RAM_BASE,           0,            1, 32'h0000BEEF, 0, 0));
    vt.push_back(mk(0, OP_LW,  RAM_BASE,           0,            1, 32'hDEADBEEF, 0, 0));
    vt.push_back(mk(1, OP_LW,  RAM_BASE + 4,       0,            0, 32'h0,        0, 0));
    vt.push_back(mk(1, OP_LB,  RAM_BASE + 5,       32'h12,       1, 32'h0,        0, 0));
    vt.push_back(mk(1, OP_LH,  RAM_BASE + 6,       32'h3456,     1, 32'h0,        0, 0));
    vt.push_back(mk(0, OP_LW,  RAM_BASE + 4,       0,            1, 32'h34561200, 0, 0));
    vt.push_back(mk(1, OP_LW,  RAM_BASE + 2,       32'hFFFFFFFF, 1, 32'h0,        0, 1));
    vt.push_back(mk(0, OP_LW,  RAM_BASE,           0,            1, 32'hDEADBEEF, 0, 1));
    vt.push_back(mk(0, OP_LW,  A_ST,               0,            1, 32'h1,        0, 1));
    vt.push_back(mk(0, OP_LW,  A_EA,               0,            1, 32'h00100002, 0, 1));
    vt.push_back(mk(1, OP_LW,  A_ST,               0,            1, 32'h1,        0, 0));
    vt.push_back(mk(0, OP_LW,  A_ST,               0,            1, 32'h0,        0, 0));
    vt.push_back(mk(0, OP_LW,  32'h0000_1000,      0,            1, 32'h0,        0, 1));
    vt.push_back(mk(0, OP_LW,  A_ST,               0,            1, 32'h2,        0, 1));
    vt.push_back(mk(1, OP_LW,  A_LED,              32'hA5,       1, 32'h0,    32'hA5, 1));
    vt.push_back(mk(1, OP_LB,  A_LED,              32'h77,       1, 32'h0,    32'hA5, 1));
    vt.push_back(mk(0, OP_LW,  A_ST,               0,            1, 32'h3,    32'hA5, 1));
    vt.push_back(mk(0, OP_LW,  A_LED,              0,            1, 32'hA5,   32'hA5, 1));
    vt.push_back(mk(1, OP_LW,  A_ST,               0,            1, 32'h3,    32'hA5, 0));
    vt.push_back(mk(1, OP_LW,  A_EA,               32'h12345678, 1, 32'h00200000, 32'hA5, 0));
    vt.push_back(mk(0, OP_LW,  A_EA,               0,            1, 32'h00200000, 32'hA5, 0));
    vt.push_back(mk(1, OP_LW,  MMIO_BASE + 32'h1C, 32'h99,       1, 32'h0,    32'hA5, 0));
    vt.push_back(mk(0, OP_LW,  MMIO_BASE + 32'h14, 0,            1, 32'h0,    32'hA5, 0));
    vt.push_back(mk(1, OP_LBU, RAM_BASE + 7,       32'hAB,       1, 32'h34,   32'hA5, 0));
    vt.push_back(mk(0, OP_LW,  RAM_BASE + 4,       0,            1, 32'hAB561200, 32'hA5, 0));
    vt.push_back(mk(0, OP_LH,  RAM_BASE + 1,       0,            1, 32'h0,    32'hA5, 1));
    vt.push_back(mk(0, OP_LW,  A_EA,               0,            1, 32'h00100001, 32'hA5, 1));
    vt.push_back(mk(1, OP_LW,  A_ST,               0,            1, 32'h1,    32'hA5, 0));
    vt.push_back(mk(0, OP_LW,  32'h0012_0000,      0,            1, 32'h0,    32'hA5, 1));
    vt.push_back(mk(0, OP_LW,  MMIO_BASE + 32'h20, 0,            1, 32'h0,    32'hA5, 1));
    vt.push_back(mk(0, OP_LW,  A_EA,               0,            1, 32'h00200020, 32'hA5, 1));
    vt.push_back(mk(1, OP_LW,  A_ST,               0,            1, 32'h2,    32'hA5, 0));

    foreach (vt[i]) begin
      step(vt[i].we, vt[i].op, vt[i].addr, vt[i].data);
      if (vt[i].cd) chk($sformatf("row%0d dout", i), dmemdataout, vt[i].dout);
      chk($sformatf("row%0d leds", i), leds, vt[i].leds);
      chk($sformatf("row%0d err", i), err, vt[i].err);
    end

    // Counter wrap: low word read at 0xFFFFFFFF snapshots high word 0
    dmemwe = 1'b0; dmemop = OP_LW; dmemaddr = A_CLO;
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    #2;
    release dut.cycle_cnt;
    @(posedge clk);
    @(negedge clk);
    chk("cyc_lo at wrap", dmemdataout, 32'hFFFF_FFFF);
    step(0, OP_LW, A_CHI, 0);
    chk("cyc_hi shadow", dmemdataout, 32'h0);
    step(0, OP_LW, A_CLO, 0);
    chk("cyc_lo after wrap", dmemdataout, 32'h1);
    step(0, OP_LW, A_CHI, 0);
    chk("cyc_hi resnap", dmemdataout, 32'h1);

    // Async reset between posedges during a load
    step(0, OP_LW, 32'h0000_1000, 0);
    chk("pre-reset err", err, 1'b1);
    dmemwe = 1'b0; dmemop = OP_LW; dmemaddr = RAM_BASE;
    @(posedge clk);
    #2;
    chk("pre-reset dout", dmemdataout, 32'hDEADBEEF);
    clr = 1'b1;
    #1;
    chk("clr dout", dmemdataout, 32'h0);
    chk("clr leds", leds, 32'h0);
    chk("clr err", err, 1'b0);
    chk("clr counter", dut.cycle_cnt, 64'h0);
    @(negedge clk);
    clr = 1'b0;
    step(0, OP_LW, RAM_BASE, 0);
    chk("ram kept w0", dmemdataout, 32'hDEADBEEF);
    step(0, OP_LW, RAM_BASE + 4, 0);
    chk("ram kept w1", dmemdataout, 32'hAB561200);
    chk("post-reset leds", leds, 32'h0);

    // Randomized phase against the reference model (state matches reset)
    st_m = '0; leds_m = '0; ea_m = '0;
    for (int n = 0; n < 16; n++) begin
      a = RAM_BASE + 32'h100 + 32'(4*n);
      d = $urandom;
      model(1'b1, OP_LW, a, d, e, k);
      step(1'b1, OP_LW, a, d);
      chk("seed err", err, |st_m);
    end
    for (int n = 0; n < 600; n++) begin
      a  = rand_addr();
      op = ops[$urandom_range(0, 4)];
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      // Occasional clean STATUS clear keeps both error bits exercised
      if ($urandom_range(0, 15) == 0) begin a = A_ST; op = OP_LW; we = 1'b1; end
      model(we, op, a, d, e, k);
      step(we, op, a, d);
      if (k) chk($sformatf("rnd%0d dout a=%h op=%0d we=%0b", n, a, op, we), dmemdataout, e);
      chk($sformatf("rnd%0d leds", n), leds, leds_m);
      chk($sformatf("rnd%0d err", n), err, |st_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
